// File: rtl/uart_echo_if.sv
// Parallel-port handshake bundle between the echo host and the uart core.
interface uart_echo_if;
  logic       uart_rda;
  logic       uart_tbe;
  logic [7:0] uart_rx_data;
  logic       uart_rd;
  logic       uart_wr;
  logic [7:0] uart_tx_data;

  modport master (
    input  uart_rda, uart_tbe, uart_rx_data,
    output uart_rd, uart_wr, uart_tx_data
  );

  modport slave (
    output uart_rda, uart_tbe, uart_rx_data,
    input  uart_rd, uart_wr, uart_tx_data
  );
endinterface

// File: rtl/uart_echo_host.sv
// Host-side echo controller for the uart parallel port: RX FSM pulls bytes
// into a FWFT FIFO, TX FSM echoes them back, optionally expanding CR to CR,LF.
//
// RX state  | meaning
// R_IDLE    | waiting for enable before requesting a byte
// R_REQ     | raise rd
// R_WAITLO  | rd held, wait for the uart to drop rda (armed)
// R_WAITHI  | rd held, wait for rda; capture and push the byte
// R_ACK     | rd dropped, 4 clk settle for the uart
//
// TX state  | meaning
// T_IDLE    | wait for data, tbe and enable; pop FIFO head
// T_LOAD    | present popped byte, raise wr
// T_WAITLO  | wr held, wait for tbe low (byte latched)
// T_WAITHI  | wr held, wait for tbe high (frame sent)
// T_DROP    | wr dropped, 4 clk settle, then LF or idle
// T_LF      | present 0x0A, raise wr
module uart_echo_host #(
  parameter int FIFO_AW   = 4,
  parameter bit EXPAND_CR = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  uart_echo_if.master        uart,
  output logic [FIFO_AW:0]   fifo_level_o,
  output logic               overflow_o,
  output logic [15:0]        rx_count_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   LVL_FULL = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]   LVL_ONE  = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

  localparam logic [2:0] R_IDLE = 3'd0, R_REQ = 3'd1, R_WAITLO = 3'd2,
                         R_WAITHI = 3'd3, R_ACK = 3'd4;
  localparam logic [2:0] T_IDLE = 3'd0, T_LOAD = 3'd1, T_WAITLO = 3'd2,
                         T_WAITHI = 3'd3, T_DROP = 3'd4, T_LF = 3'd5;

  logic [2:0]         rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic [1:0]         rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic               rda_m_q, rda_s_q, tbe_m_q, tbe_s_q;
  logic               wr_q, wr_d;
  logic [7:0]         tx_data_q, tx_data_d, hold_q, hold_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        rx_count_q, rx_count_d;
  logic               push, push_ok, pop;
  logic [7:0]         mem_q [DEPTH];

  // RX handshake: request, wait for a fresh rda rising, capture, settle.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_count_d = rx_count_q;
    push       = 1'b0;
    case (rx_state_q)
      R_IDLE:   if (enable_i) rx_state_d = R_REQ;
      R_REQ:    rx_state_d = R_WAITLO;
      R_WAITLO: if (!rda_s_q) rx_state_d = R_WAITHI;
      R_WAITHI: if (rda_s_q) begin
        push       = 1'b1;
        rx_count_d = rx_count_q + 16'd1;
        rx_cnt_d   = 2'd3;
        rx_state_d = R_ACK;
      end
      R_ACK:    if (rx_cnt_q == 2'd0) rx_state_d = R_IDLE;
                else rx_cnt_d = rx_cnt_q - 2'd1;
      default:  rx_state_d = R_IDLE;
    endcase
  end

  // TX handshake: pop, drive wr with stable data, settle, optional LF.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_data_d  = tx_data_q;
    wr_d       = wr_q;
    hold_d     = hold_q;
    pop        = 1'b0;
    case (tx_state_q)
      T_IDLE:   if ((level_q != '0) && tbe_s_q && enable_i) begin
        pop        = 1'b1;
        hold_d     = mem_q[rd_ptr_q];
        tx_state_d = T_LOAD;
      end
      T_LOAD:   begin
        tx_data_d  = hold_q;
        wr_d       = 1'b1;
        tx_state_d = T_WAITLO;
      end
      T_WAITLO: if (!tbe_s_q) tx_state_d = T_WAITHI;
      T_WAITHI: if (tbe_s_q) begin
        wr_d       = 1'b0;
        tx_cnt_d   = 2'd3;
        tx_state_d = T_DROP;
      end
      T_DROP:   begin
        if (tx_cnt_q != 2'd0) tx_cnt_d = tx_cnt_q - 2'd1;
        else if (EXPAND_CR && (tx_data_q == 8'h0D)) begin
          // A pending LF waits here while disabled so the CR,LF pair stays intact.
          if (enable_i) tx_state_d = T_LF;
        end
        else tx_state_d = T_IDLE;
      end
      T_LF:     begin
        tx_data_d  = 8'h0A;
        wr_d       = 1'b1;
        tx_state_d = T_WAITLO;
      end
      default:  tx_state_d = T_IDLE;
    endcase
  end

  // FIFO bookkeeping; a push into a full FIFO is dropped and flagged.
  always_comb begin
    push_ok    = push && (level_q != LVL_FULL);
    overflow_d = overflow_q | (push && (level_q == LVL_FULL));
    wr_ptr_d   = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // State, synchronizer and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= R_IDLE;
      tx_state_q <= T_IDLE;
      rx_cnt_q   <= 2'd0;
      tx_cnt_q   <= 2'd0;
      rda_m_q    <= 1'b0;
      rda_s_q    <= 1'b0;
      tbe_m_q    <= 1'b0;
      tbe_s_q    <= 1'b0;
      wr_q       <= 1'b0;
      tx_data_q  <= 8'h00;
      hold_q     <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      rx_count_q <= 16'd0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      rda_m_q    <= uart.uart_rda;
      rda_s_q    <= rda_m_q;
      tbe_m_q    <= uart.uart_tbe;
      tbe_s_q    <= tbe_m_q;
      wr_q       <= wr_d;
      tx_data_q  <= tx_data_d;
      hold_q     <= hold_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      rx_count_q <= rx_count_d;
    end
  end

  // FIFO storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem_q[wr_ptr_q] <= uart.uart_rx_data;
  end

  assign uart.uart_rd      = (rx_state_q == R_REQ) || (rx_state_q == R_WAITLO) ||
                             (rx_state_q == R_WAITHI);
  assign uart.uart_wr      = wr_q;
  assign uart.uart_tx_data = tx_data_q;
  assign fifo_level_o      = level_q;
  assign overflow_o        = overflow_q;
  assign rx_count_o        = rx_count_q;

endmodule

// File: tb/tb_uart_echo_host.sv
// Bench for uart_echo_host: a CR-expanding instance and a verbatim instance
// share one RX uart model; each has its own TX uart model and echo log.
module tb_uart_echo_host;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       rda;
  logic [7:0] rxd;
  logic       tbe_r [2];
  logic       tbe_block;
  logic       tx_long;

  logic [4:0]  lvl0, lvl1;
  logic        ovf0, ovf1;
  logic [15:0] cnt0, cnt1;

  logic [7:0] tx_log [2][64];
  int         tx_n [2];
  int         hold_err [2];

  int checks = 0;
  int errors = 0;
  int exp_rx;

  uart_echo_if u0 ();
  uart_echo_if u1 ();

  assign u0.uart_rda = rda;
  assign u1.uart_rda = rda;
  assign u0.uart_rx_data = rxd;
  assign u1.uart_rx_data = rxd;
  assign u0.uart_tbe = tbe_r[0];
  assign u1.uart_tbe = tbe_r[1];

  uart_echo_host #(.FIFO_AW(4), .EXPAND_CR(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .uart(u0),
    .fifo_level_o(lvl0), .overflow_o(ovf0), .rx_count_o(cnt0));

  uart_echo_host #(.FIFO_AW(4), .EXPAND_CR(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .uart(u1),
    .fifo_level_o(lvl1), .overflow_o(ovf1), .rx_count_o(cnt1));

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] rx;
    int         n_a;
    logic [7:0] a0;
    logic [7:0] a1;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // TX side uart model for both instances.
  initial begin
    int         ph [2];
    int         tmr [2];
    logic [7:0] last [2];
    logic       wr;
    logic [7:0] d;
    for (int g = 0; g < 2; g++) begin
      ph[g] = 0; tmr[g] = 0; last[g] = 8'h00; tbe_r[g] = 1'b1;
      tx_n[g] = 0; hold_err[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        wr = (g == 0) ? u0.uart_wr : u1.uart_wr;
        d  = (g == 0) ? u0.uart_tx_data : u1.uart_tx_data;
        if (!rst_n) begin
          ph[g] = 0;
          tbe_r[g] = !tbe_block;
        end else begin
          case (ph[g])
            0: begin
              tbe_r[g] = !tbe_block;
              if (wr && !tbe_block) begin
                if (tx_n[g] < 64) tx_log[g][tx_n[g]] = d;
                tx_n[g]++;
                last[g] = d;
                tbe_r[g] = 1'b0;
                tmr[g] = tx_long ? 60 : 6;
                ph[g] = 1;
              end
            end
            1: begin
              if (wr && d !== last[g]) hold_err[g]++;
              if (tmr[g] == 0) begin tbe_r[g] = 1'b1; ph[g] = 2; end
              else tmr[g]--;
            end
            default: begin
              if (wr && d !== last[g]) hold_err[g]++;
              if (!wr) ph[g] = 0;
            end
          endcase
        end
      end
    end
  end

  task automatic wait_rd(input logic lvl, input string name, output logic ok);
    int n = 0;
    while (u0.uart_rd !== lvl && n < 300) begin @(negedge clk); n++; end
    ok = (u0.uart_rd === lvl);
    if (!ok) timeout(name);
  endtask

  // RX side uart model: arm (rda low), then present the byte with rda high.
  task automatic deliver(input logic [7:0] b);
    logic ok;
    wait_rd(1'b1, "deliver_rd_rise", ok);
    if (ok) begin
      repeat (2) @(negedge clk);
      rda = 1'b0;
      repeat (3) @(negedge clk);
      rxd = b;
      rda = 1'b1;
      wait_rd(1'b0, "deliver_rd_fall", ok);
      exp_rx++;
    end
  endtask

  task automatic wait_logs(input int n0, input int n1, input int lim, input string name);
    int n = 0;
    while (!(tx_n[0] >= n0 && tx_n[1] >= n1) && n < lim) begin @(negedge clk); n++; end
    if (!(tx_n[0] >= n0 && tx_n[1] >= n1)) timeout(name);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_rx = 0;
  endtask

  initial begin
    int b0, b1, lat, snap0, snap1;
    logic ok;
    logic [7:0] exp_a [$];

    vecs[0] = '{8'h41, 1, 8'h41, 8'h00};
    vecs[1] = '{8'h0D, 2, 8'h0D, 8'h0A};
    vecs[2] = '{8'h0A, 1, 8'h0A, 8'h00};
    vecs[3] = '{8'hFF, 1, 8'hFF, 8'h00};
    vecs[4] = '{8'h00, 1, 8'h00, 8'h00};
    vecs[5] = '{8'h0D, 2, 8'h0D, 8'h0A};
    vecs[6] = '{8'h7E, 1, 8'h7E, 8'h00};

    rst_n = 1'b0; enable = 1'b1; rda = 1'b1; rxd = 8'hA5;
    tbe_block = 1'b0; tx_long = 1'b0; exp_rx = 0;

    // Reset held 3 clk with rda/tbe active.
    repeat (3) @(negedge clk);
    chk("rst_rd", u0.uart_rd, 0);
    chk("rst_wr", u0.uart_wr, 0);
    chk("rst_txdata", u0.uart_tx_data, 8'h00);
    chk("rst_level", lvl0, 0);
    chk("rst_overflow", ovf0, 0);
    chk("rst_rxcount", cnt0, 0);
    chk("rst_wr_b", u1.uart_wr, 0);
    chk("rst_level_b", lvl1, 0);
    rst_n = 1'b1;

    // Push-to-wr latency with TX idle and tbe high.
    deliver(8'h5A);
    lat = 0;
    while (!u0.uart_wr && lat < 20) begin @(negedge clk); lat++; end
    chk("latency", lat, 2);
    wait_logs(1, 1, 300, "latency_echo");
    chk("latency_data", tx_log[0][0], 8'h5A);
    chk("latency_data_b", tx_log[1][0], 8'h5A);

    // Table-driven echo vectors.
    for (int i = 0; i < 7; i++) begin
      b0 = tx_n[0]; b1 = tx_n[1];
      deliver(vecs[i].rx);
      wait_logs(b0 + vecs[i].n_a, b1 + 1, 400, $sformatf("vec%0d_echo", i));
      chk($sformatf("vec%0d_a0", i), tx_log[0][b0], vecs[i].a0);
      if (vecs[i].n_a == 2) chk($sformatf("vec%0d_a1", i), tx_log[0][b0 + 1], vecs[i].a1);
      chk($sformatf("vec%0d_b", i), tx_log[1][b1], vecs[i].rx);
      chk($sformatf("vec%0d_rxcount", i), cnt0, exp_rx);
      chk($sformatf("vec%0d_level", i), lvl0, 0);
    end
    repeat (80) @(negedge clk);
    chk("vec_total_a", tx_n[0], 10);
    chk("vec_total_b", tx_n[1], 8);

    // Stale rda: still high from the previous byte when rd rises.
    wait_rd(1'b1, "stale_rd_rise", ok);
    repeat (10) @(negedge clk);
    chk("stale_rd_held", u0.uart_rd, 1);
    chk("stale_no_push", cnt0, exp_rx);
    chk("stale_level", lvl0, 0);
    rda = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 8'h55; rda = 1'b1;
    wait_rd(1'b0, "stale_rd_fall", ok);
    exp_rx++;
    chk("stale_push", cnt0, exp_rx);
    wait_logs(11, 9, 300, "stale_echo");
    chk("stale_echo_a", tx_log[0][10], 8'h55);
    chk("stale_echo_b", tx_log[1][8], 8'h55);

    // Overflow: tbe held low, 17 bytes into a 16-deep FIFO.
    repeat (40) @(negedge clk);
    tbe_block = 1'b1;
    pulse_reset();
    snap0 = tx_n[0]; snap1 = tx_n[1];
    for (int i = 0; i < 17; i++) deliver(8'(i));
    repeat (4) @(negedge clk);
    chk("ovf_level", lvl0, 16);
    chk("ovf_flag", ovf0, 1);
    chk("ovf_rxcount", cnt0, 17);
    chk("ovf_level_b", lvl1, 16);
    chk("ovf_flag_b", ovf1, 1);
    exp_a.delete();
    for (int i = 0; i < 16; i++) begin
      exp_a.push_back(8'(i));
      if (i == 13) exp_a.push_back(8'h0A);
    end
    tbe_block = 1'b0;
    wait_logs(snap0 + 17, snap1 + 16, 3000, "ovf_drain");
    repeat (100) @(negedge clk);
    chk("ovf_count_a", tx_n[0] - snap0, 17);
    chk("ovf_count_b", tx_n[1] - snap1, 16);
    for (int i = 0; i < 17; i++)
      chk($sformatf("ovf_a%0d", i), tx_log[0][snap0 + i], exp_a[i]);
    for (int i = 0; i < 16; i++)
      chk($sformatf("ovf_b%0d", i), tx_log[1][snap1 + i], 8'(i));
    chk("ovf_sticky", ovf0, 1);
    chk("ovf_rxcount_end", cnt0, 17);
    chk("ovf_drained", lvl0, 0);

    // Reset while TX sits in T_WAITHI with one byte still queued.
    pulse_reset();
    tx_long = 1'b1;
    deliver(8'h33);
    deliver(8'h34);
    repeat (2) @(negedge clk);
    chk("midtx_wr_pre", u0.uart_wr, 1);
    chk("midtx_tbe_pre", tbe_r[0], 0);
    chk("midtx_level_pre", lvl0, 1);
    snap0 = tx_n[0]; snap1 = tx_n[1];
    rst_n = 1'b0;
    @(negedge clk);
    chk("midtx_wr", u0.uart_wr, 0);
    chk("midtx_level", lvl0, 0);
    chk("midtx_rd", u0.uart_rd, 0);
    chk("midtx_wr_b", u1.uart_wr, 0);
    rst_n = 1'b1;
    tx_long = 1'b0;
    repeat (100) @(negedge clk);
    chk("midtx_no_wr", tx_n[0], snap0);
    chk("midtx_no_wr_b", tx_n[1], snap1);
    chk("midtx_wr_low", u0.uart_wr, 0);

    chk("hold_data_a", hold_err[0], 0);
    chk("hold_data_b", hold_err[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
